// File: rtl/mem_stall_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stall_ctrl
//   Pipeline hazard and data-memory stall controller. A four-state FSM
//   (IDLE, WAIT, DONE, ERR) sequences each ME-stage load/store against a
//   memory that acknowledges with a one-cycle memAck pulse, and raises a
//   sticky timeout error if the ack never arrives. The stall/flush outputs
//   combine the memory stall with branch-taken flushes and load-use
//   interlocks, in priority order memory stall > branch > load-use.
//
// Parameters
//   TIMEOUT      WAIT cycles allowed without memAck before ERR (1..15)
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   memRead      load in ME stage
//   memWrite     store in ME stage
//   memAck       data memory completion pulse
//   exMemRead    load in EX stage
//   exRd         EX-stage destination register
//   idRs1/idRs2  ID-stage source registers
//   branchTaken  branch/jump resolved taken in EX
//   memReq       registered request to data memory
//   stallIF..WB  hold PC and the IF/ID, ID/EX, EX/ME, ME/WB registers
//   flushID/EX   bubble the IF/ID and ID/EX registers
//   memErr       registered sticky timeout flag
// ---------------------------------------------------------------------------
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       memRead,
  input  logic       memWrite,
  input  logic       memAck,
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       branchTaken,
  output logic       memReq,
  output logic       stallIF,
  output logic       stallID,
  output logic       stallEX,
  output logic       stallME,
  output logic       stallWB,
  output logic       flushID,
  output logic       flushEX,
  output logic       memErr
);

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned REG_W   = 5;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;
  localparam logic [STATE_W-1:0] ST_ERR  = 2'd3;

  // Last counter value tolerated in WAIT before declaring a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_err_q, mem_err_d;

  logic               mem_access;
  logic               mem_stall;
  logic               load_use;

  assign mem_access = memRead | memWrite;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic; memAck only matters in WAIT and wins over the timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = 1'b0;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_access) begin
          state_d   = ST_WAIT;
          cnt_d     = '0;
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (memAck) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_ERR;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d   = ST_ERR;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign memReq = mem_req_q;
  assign memErr = mem_err_q;

  // Memory stall: covers the request cycle in IDLE, all of WAIT and ERR.
  // DONE is deliberately stall-free so ME/WB captures the access result.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: mem_stall = mem_access;
      ST_WAIT: mem_stall = 1'b1;
      ST_ERR:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Load-use hazard; x0 is never a real dependency.
  assign load_use = exMemRead & (exRd != REG_W'(0)) &
                    ((exRd == idRs1) | (exRd == idRs2));

  // Stall/flush resolution: memory stall > branch flush > load-use bubble.
  always_comb begin
    stallIF = 1'b0;
    stallID = 1'b0;
    stallEX = 1'b0;
    stallME = 1'b0;
    stallWB = 1'b0;
    flushID = 1'b0;
    flushEX = 1'b0;
    if (mem_stall) begin
      stallIF = 1'b1;
      stallID = 1'b1;
      stallEX = 1'b1;
      stallME = 1'b1;
      stallWB = 1'b1;
    end else if (branchTaken) begin
      flushID = 1'b1;
      flushEX = 1'b1;
    end else if (load_use) begin
      stallIF = 1'b1;
      stallID = 1'b1;
      flushEX = 1'b1;
    end
  end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, max WAIT-state cycles without memAck before error; 1..15.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 memRead  input  1  load in ME stage (from EX/ME register).
REQ-005 memWrite  input  1  store in ME stage (from EX/ME register).
REQ-006 memAck  input  1  data memory completion, one-cycle pulse.
REQ-007 exMemRead  input  1  load in EX stage.
REQ-008 exRd  input  5  EX-stage destination register.
REQ-009 idRs1, idRs2  input  5 each  ID-stage source registers.
REQ-010 branchTaken  input  1  branch/jump resolved taken in EX.
REQ-011 memReq  output  1  registered request to data memory.
REQ-012 stallIF, stallID, stallEX, stallME, stallWB  output  1 each  hold PC and the IF/ID, ID/EX, EX/ME, ME/WB registers.
REQ-013 flushID, flushEX  output  1 each  zero the IF/ID and ID/EX registers (bubble).
REQ-014 memErr  output  1  registered sticky timeout flag.

Function
REQ-015 The block SHALL implement the FSM IDLE, WAIT, DONE, ERR with a 4-bit wait counter cnt.
REQ-016 IDLE: when memRead|memWrite is 1, the block SHALL go to WAIT, set memReq=1 and clear cnt at the next edge; otherwise it SHALL remain in IDLE.
REQ-017 WAIT: memReq SHALL stay 1; memAck=1 SHALL move to DONE with memReq=0; otherwise cnt SHALL increment by 1.
REQ-018 WAIT with memAck=0 and cnt==TIMEOUT-1 SHALL move to ERR, set memErr=1 and memReq=0; memAck=1 in that cycle SHALL take priority and move to DONE.
REQ-019 DONE: the block SHALL return to IDLE unconditionally after one cycle; memReq SHALL be 0.
REQ-020 ERR: the block SHALL stay in ERR until rst; memErr=1, memReq=0.
REQ-021 memAck in IDLE, DONE or ERR SHALL be ignored.
REQ-022 memStall (combinational) SHALL be 1 in IDLE with memRead|memWrite, in WAIT, and in ERR; it SHALL be 0 in DONE.
REQ-023 memStall=1 SHALL assert all five stall outputs and force flushID=flushEX=0.
REQ-024 The DONE cycle SHALL release all stalls so ME/WB captures the access result and the next instruction enters ME; each access therefore costs 2 + (cycles to ack) stall cycles.
REQ-025 loadUse SHALL be exMemRead & (exRd!=0) & (exRd==idRs1 | exRd==idRs2), combinational.
REQ-026 With memStall=0 and branchTaken=1, the block SHALL assert flushID=flushEX=1 and no stalls; loadUse SHALL be ignored.
REQ-027 With memStall=0, branchTaken=0 and loadUse=1, the block SHALL assert stallIF=stallID=1 and flushEX=1; stallEX, stallME and stallWB SHALL be 0.
REQ-028 Otherwise all stall and flush outputs SHALL be 0.
REQ-029 Priority SHALL be: memStall > branchTaken > loadUse.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force state=IDLE, cnt=0, memReq=0 and memErr=0, including mid-WAIT and in ERR.
REQ-031 The combinational outputs SHALL follow the inputs in IDLE during reset; memReq SHALL remain 0 until the first edge after rst rises.

Verification
REQ-032 Load with ack 3 cycles after memReq rises -> stalls high for 5 cycles (IDLE, 3xWAIT, WAIT with ack), low in DONE; memReq high exactly 4 cycles.
REQ-033 Store with memAck withheld, TIMEOUT=15 -> ERR after 15 WAIT cycles, memErr=1, stalls held; rst pulse -> IDLE and all outputs 0.
REQ-034 exMemRead=1, exRd=5, idRs2=5, no ME access -> stallIF=stallID=flushEX=1 for that cycle; exRd=0 with idRs1=0 -> no stall.
REQ-035 branchTaken=1 together with loadUse=1 -> flushID=flushEX=1, stallIF=0; the same with memStall=1 -> all stalls 1 and no flush.
REQ-036 rst asserted during WAIT at cnt=7 -> memReq falls before the next edge; a later access restarts cnt from 0.
REQ-037 memAck exactly at cnt==TIMEOUT-1 -> DONE, memErr stays 0.
